// File: rtl/pipe_credit_scheduler.sv
// Flow controller wrapping a free-running fixed-latency datapath as a valid/ready stage.
// Accepted words are tagged in a valid shift chain that tracks the external pipe; tagged
// words are captured into a skid FIFO, and upstream credit is withheld so the FIFO can
// always absorb every word still inside the pipe.
module pipe_credit_scheduler #(
    parameter int unsigned NPIPE_DEPTH = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] pipe_in_data,
    input  logic [DATA_WIDTH-1:0] pipe_out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      inflight_count,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [NPIPE_DEPTH-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;

    logic                   accept;
    logic                   capture;
    logic                   pop;
    logic [SUM_W-1:0]       credit_used;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode and credit; credit uses registered counts only.
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
        in_ready    = reset && !flush && (credit_used < SUM_W'(FIFO_DEPTH));
        accept      = in_valid && in_ready;
        capture     = vld_q[NPIPE_DEPTH-1];
        out_valid   = (fifo_cnt_q != '0);
        pop         = out_valid && out_ready;
    end

    // Output view of the FIFO head and status.
    always_comb begin
        pipe_in_data   = in_data;
        out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
        inflight_count = inflight_q;
        fifo_count     = fifo_cnt_q;
        busy           = (inflight_q != '0) || (fifo_cnt_q != '0);
    end

    // Valid tag chain mirroring the datapath stages.
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            vld_d[0] = accept;
            for (int i = 1; i < NPIPE_DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // In-flight word counter: up on accept, down on capture.
    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (accept && !capture) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (capture && !accept) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Skid FIFO: capture at tail, pop at head, flush clears occupancy.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (capture) begin
                mem_d[wr_ptr_q] = pipe_out_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (capture && !pop) begin
                fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            end else if (pop && !capture) begin
                fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
            mem_q      <= mem_d;
        end
    end

    // Credit accounting must make a capture into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        (capture && !flush) |-> (fifo_cnt_q != CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_pipe_credit_scheduler.sv
// Bench for pipe_credit_scheduler: models the external fixed-latency pipe, keeps a
// scoreboard of accepted words, and runs a vector table plus corner-case sequences.
module tb_pipe_credit_scheduler;

    localparam int unsigned D  = 3;
    localparam int unsigned W  = 32;
    localparam int unsigned F  = 8;
    localparam int unsigned CW = 4;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  pipe_in_data;
    logic [W-1:0]  pipe_out_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] inflight_count;
    logic [CW-1:0] fifo_count;
    logic          busy;

    pipe_credit_scheduler #(
        .NPIPE_DEPTH(D), .DATA_WIDTH(W), .FIFO_DEPTH(F), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .inflight_count(inflight_count), .fifo_count(fifo_count), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External datapath: plain D-stage free-running register chain.
    logic [W-1:0] pipe_q [D];
    always @(posedge clock) begin
        pipe_q[0] <= pipe_in_data;
        for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign pipe_out_data = pipe_q[D-1];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q [$];
    int cyc = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int first_pop = -1;
    int last_pop = -1;

    typedef struct {
        logic          iv;
        logic [W-1:0]  din;
        logic          ordy;
        logic          e_irdy;
        logic          e_ovld;
        logic [CW-1:0] e_infl;
        logic [CW-1:0] e_fcnt;
        logic          e_busy;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard update for the cycle about to end; call between negedge and posedge.
    task automatic sb_update();
        logic [W-1:0] exp;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp = sb_q.pop_front();
                    check("out_data", out_data, exp);
                end
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                acc_cnt++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic step();
        @(negedge clock);
        sb_update();
        advance();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic clr_stats();
        acc_cnt = 0;
        pop_cnt = 0;
        first_pop = -1;
        last_pop = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drops;
        //                iv  din       ordy irdy ovld infl fcnt busy
        tbl[0]  = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1};
        tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[6]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[7]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 1'b1};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b1};
        tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0};

        // Reset held with upstream asserting valid.
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        advance();

        // Latency and simultaneous write/pop vectors.
        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].din; out_ready = tbl[i].ordy;
            @(negedge clock);
            check($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            check($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ovld));
            check($sformatf("row%0d_inflight", i), 32'(inflight_count), 32'(tbl[i].e_infl));
            check($sformatf("row%0d_fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_fcnt));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            sb_update();
            advance();
        end

        // Full-rate streaming.
        clr_stats();
        drops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            @(negedge clock);
            if (!in_ready) drops++;
            sb_update();
            advance();
        end
        in_valid = 1'b0;
        drain("thru_drain", 50);
        check("thru_drops", 32'(drops), 32'd0);
        check("thru_pops", 32'(pop_cnt), 32'd100);
        check("thru_span", 32'(last_pop - first_pop), 32'd99);

        // Backpressure: credit limits acceptance to the FIFO depth.
        clr_stats();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 32'(1000 + i);
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc_cnt), 32'd8);
        @(negedge clock);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_fifo_count", 32'(fifo_count), 32'd8);
        check("bp_inflight", 32'(inflight_count), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_credit_lag", 32'(in_ready), 32'd0);
        sb_update();
        advance();
        @(negedge clock);
        check("bp_credit_back", 32'(in_ready), 32'd1);
        sb_update();
        advance();
        drain("bp_drain", 20);
        check("bp_pops", 32'(pop_cnt), 32'd8);
        @(negedge clock);
        check("bp_in_ready_end", 32'(in_ready), 32'd1);
        advance();

        // Flush with two words in the FIFO and three in the pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'(3000 + i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("fl_pre_fifo", 32'(fifo_count), 32'd2);
        check("fl_pre_inflight", 32'(inflight_count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        sb_update();
        advance();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_fifo", 32'(fifo_count), 32'd0);
        check("fl_inflight", 32'(inflight_count), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("fl_post%0d_fifo", i), 32'(fifo_count), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'(4000 + i);
            step();
        end
        in_valid = 1'b0;
        drain("fl_drain", 20);

        // Asynchronous reset with five words queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'(5000 + i);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("ar_pre_fifo", 32'(fifo_count), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_data", out_data, 32'd0);
        check("ar_fifo", 32'(fifo_count), 32'd0);
        check("ar_inflight", 32'(inflight_count), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        @(negedge clock);
        reset = 1'b1;
        advance();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'(6000 + i);
            step();
        end
        in_valid = 1'b0;
        drain("ar_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
